// File: rtl/aes_pkg.sv
// Shared AES-128 constants and GF(2^8) helpers: S-box, Rcon, xtime, MixColumns column transform.
package aes_pkg;

    localparam int unsigned NR = 10;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column bytes a0..a3 are packed MSB first (a0 = bits 31:24).
    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box lookup for one byte.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    assign y = SBOX[a];

endmodule

// File: rtl/aes128_main.sv
// Iterative AES-128 encrypt core: one round per clock, round keys expanded on the fly.
module aes128_main
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] data,
    input  logic [127:0] key128,
    output logic [127:0] out128,
    output logic         busy,
    output logic         done
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]   fsm;
    logic [3:0]   cnt;
    logic [127:0] st;
    logic [127:0] rk;

    logic [127:0] sb;
    logic [127:0] sr;
    logic [127:0] mc;
    logic [127:0] nrk;
    logic [127:0] nst;
    logic [31:0]  rotw;
    logic [31:0]  subw;
    logic [7:0]   rc;
    logic [3:0]   ridx;
    logic         last;

    // Byte i of the state sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
    for (genvar i = 0; i < 16; i++) begin : g_sub
        aes_sbox u_sbox (
            .a(st[127-8*i -: 8]),
            .y(sb[127-8*i -: 8])
        );
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
        end
        assign mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
    end

    assign rotw = {rk[23:0], rk[31:24]};

    for (genvar j = 0; j < 4; j++) begin : g_subword
        aes_sbox u_sbox (
            .a(rotw[31-8*j -: 8]),
            .y(subw[31-8*j -: 8])
        );
    end

    assign ridx = cnt - 4'd1;
    assign last = (cnt == 4'(NR));

    always_comb begin
        rc = '0;
        if (cnt >= 4'd1 && cnt <= 4'(NR)) begin
            rc = RCON[ridx];
        end
    end

    always_comb begin
        nrk = '0;
        nrk[127:96] = rk[127:96] ^ subw ^ {rc, 24'h000000};
        nrk[95:64]  = rk[95:64]  ^ nrk[127:96];
        nrk[63:32]  = rk[63:32]  ^ nrk[95:64];
        nrk[31:0]   = rk[31:0]   ^ nrk[63:32];
    end

    assign nst = (last ? sr : mc) ^ nrk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm    <= S_IDLE;
            cnt    <= '0;
            st     <= '0;
            rk     <= '0;
            out128 <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (fsm)
                S_IDLE: begin
                    if (start) begin
                        st   <= data ^ key128;
                        rk   <= key128;
                        cnt  <= 4'd1;
                        busy <= 1'b1;
                        fsm  <= S_RUN;
                    end
                end
                default: begin
                    st <= nst;
                    rk <= nrk;
                    if (last) begin
                        out128 <= nst;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        cnt    <= '0;
                        fsm    <= S_IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_main.sv
// Self-checking bench for aes128_main using FIPS-197 / SP800-38A known-answer vectors.
module tb_aes128_main;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] data;
    logic [127:0] key128;
    logic [127:0] out128;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    logic [127:0] exp_q[$];

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] D1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] E1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] D2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] E2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K3 = 128'h0;
    localparam logic [127:0] D3 = 128'h0;
    localparam logic [127:0] E3 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] D4 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] E4 = 128'h3925841d02dc09fbdc118597196a0b32;

    aes128_main dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .data(data),
        .key128(key128),
        .out128(out128),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge following the load edge.
    task automatic launch(input logic [127:0] d, input logic [127:0] k);
        data   = d;
        key128 = k;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Counts negedges until done is seen; lat = -1 when the budget runs out.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; data = '0; key128 = '0;
        repeat (2) @(negedge clk);
        total++;
        if (out128 !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: out128=%h busy=%b done=%b, want 0/0/0", out128, busy, done);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        logic [127:0] dv [3];
        logic [127:0] kv [3];
        logic [127:0] ev [3];
        logic [127:0] e;
        int lat;
        dv = '{D1, D2, D3};
        kv = '{K1, K2, K3};
        ev = '{E1, E2, E3};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(ev[i]);
            launch(dv[i], kv[i]);
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL vec%0d_busy_rise: busy=%b want 1", i, busy);
            end
            data = ~dv[i]; key128 = ~kv[i];
            wait_done(lat);
            total++;
            if (lat !== 10) begin
                bad++;
                $display("FAIL vec%0d_latency: got %0d cycles want 10", i, lat);
            end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
            total++;
            if (out128 !== e || busy !== 1'b0) begin
                bad++;
                $display("FAIL vec%0d_result: out128=%h busy=%b want %h busy=0", i, out128, busy, e);
            end
            @(negedge clk);
            total++;
            if (done !== 1'b0 || out128 !== e) begin
                bad++;
                $display("FAIL vec%0d_hold: done=%b out128=%h want done=0 out128=%h", i, done, out128, e);
            end
        end
    endtask

    task automatic test_ignored_start();
        logic [127:0] e;
        int lat;
        int pulses;
        exp_q.push_back(E4);
        launch(D4, K1);
        repeat (3) @(negedge clk);
        launch(D1, K2);
        data = D2; key128 = K3;
        wait_done(lat);
        total++;
        if (lat !== 6) begin
            bad++;
            $display("FAIL busy_start_latency: got %0d want 6 after second start", lat);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        total++;
        if (out128 !== e) begin
            bad++;
            $display("FAIL busy_start_result: out128=%h want %h", out128, e);
        end
        pulses = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        total++;
        if (pulses !== 0 || out128 !== e) begin
            bad++;
            $display("FAIL busy_start_extra: extra activity=%0d out128=%h want 0 and %h", pulses, out128, e);
        end
    endtask

    task automatic test_start_at_completion();
        logic [127:0] e;
        exp_q.push_back(E2);
        launch(D2, K2);
        repeat (9) @(negedge clk);
        data = D3; key128 = K3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        total++;
        if (done !== 1'b1 || out128 !== e) begin
            bad++;
            $display("FAIL edge_start_done: done=%b out128=%h want 1 and %h", done, out128, e);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL edge_start_ignored: busy=%b done=%b want 0/0", busy, done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [127:0] e;
        int lat;
        launch(D4, K1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || out128 !== '0) begin
            bad++;
            $display("FAIL mid_reset: busy=%b done=%b out128=%h want 0/0/0", busy, done, out128);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_idle: busy=%b done=%b want 0/0", busy, done);
        end
        exp_q.push_back(E1);
        launch(D1, K1);
        wait_done(lat);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        total++;
        if (lat !== 10 || out128 !== e) begin
            bad++;
            $display("FAIL restart_result: lat=%0d out128=%h want 10 and %h", lat, out128, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] e;
        int lat;
        @(negedge clk);
        exp_q.push_back(E1);
        launch(D1, K1);
        wait_done(lat);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        total++;
        if (lat !== 10 || out128 !== e) begin
            bad++;
            $display("FAIL b2b_first: lat=%0d out128=%h want 10 and %h", lat, out128, e);
        end
        exp_q.push_back(E2);
        launch(D2, K2);
        total++;
        if (done !== 1'b0 || busy !== 1'b1 || out128 !== e) begin
            bad++;
            $display("FAIL b2b_pulse: done=%b busy=%b out128=%h want 0/1/%h", done, busy, out128, e);
        end
        wait_done(lat);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        total++;
        if (lat !== 10 || out128 !== e) begin
            bad++;
            $display("FAIL b2b_second: lat=%0d out128=%h want 10 and %h", lat, out128, e);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second_pulse: done=%b want 0", done);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_ignored_start();
        test_start_at_completion();
        test_reset_mid();
        test_back_to_back();
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
